cv32e40p_trace_retire_buffer: RTL and testbench
===============================================

Name: cv32e40p_trace_retire_buffer

Overview:
- In-order retirement buffer that sits directly upstream of the instruction tracer.
- Records each instruction at ID issue and holds it until its register writeback arrives. ALU writebacks arrive on the EX/WB port; loads arrive on the LSU port.
- Presents completed instructions to the tracer in program order over a valid/ready interface.
- The tracer decodes and prints the records. This block never stalls the core.

Parameters:
- DEPTH, 8, number of in-flight entries; power of two, at least 2.
- ADDR_WIDTH, 6, register address width; bit 5 selects the FP register file.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- flush_i  in  1  discard all buffered entries (trap/debug entry)
- id_valid_i  in  1  instruction issued from ID this cycle
- id_pc_i  in  32  PC of the issued instruction
- id_instr_i  in  32  decompressed instruction word
- id_rd_i  in  ADDR_WIDTH  destination register
- id_rd_we_i  in  1  instruction writes rd
- id_is_load_i  in  1  rd is written by the LSU (loads, LR, AMO)
- ex_we_i  in  1  ALU/MUL/CSR register-file write
- ex_waddr_i  in  ADDR_WIDTH  write address
- ex_wdata_i  in  32  write data
- lsu_we_i  in  1  load writeback
- lsu_waddr_i  in  ADDR_WIDTH  load write address
- lsu_wdata_i  in  32  load write data
- tr_valid_o  out  1  record available
- tr_ready_i  in  1  tracer accepts record
- tr_pc_o  out  32  record PC
- tr_instr_o  out  32  record instruction
- tr_rd_o  out  ADDR_WIDTH  record rd
- tr_rd_we_o  out  1  record carries writeback
- tr_wdata_o  out  32  written value (0 if no writeback)
- count_o  out  $clog2(DEPTH)+1  occupancy
- overflow_o  out  1  sticky: issue dropped because buffer full
- spurious_o  out  1  sticky: writeback with no matching pending entry

Behaviour:
- Reset (async, rst_n=0): pointers=0, count_o=0, all entries invalid, tr_valid_o=0, overflow_o=0, spurious_o=0. tr_* data outputs are 0.
- Entry fields: valid, done, is_load, rd_we, rd, pc, instr, wdata.
- Push (id_valid_i):
  - Entry is written at the tail.
  - done=1 immediately if id_rd_we_i=0; otherwise done=0.
- Buffer full on push:
  - Push is accepted if a pop occurs in the same cycle.
  - Otherwise the instruction is dropped and overflow_o is set. It stays set until reset; flush does not clear it.
- EX writeback (ex_we_i):
  - Matches the oldest entry, scanning from the head, with valid=1, done=0, is_load=0, rd_we=1 and rd==ex_waddr_i.
  - Matched entry gets wdata and done=1.
- LSU writeback (lsu_we_i): same matching rule, but against entries with is_load=1.
- No match on a writeback port: the write is ignored and spurious_o is set (sticky).
- Same-cycle push and writeback: writebacks match only entries present before the clock edge. The entry being pushed is never completed in its own push cycle.
- Same-cycle EX and LSU writeback: both are processed independently. They can never target the same entry.
- Output:
  - tr_valid_o = head valid & head done; tr_* are driven combinationally from the head entry.
  - Pop on tr_valid_o & tr_ready_i.
  - A non-done head blocks younger done entries; strict program order is kept.
  - tr_valid_o and the record stay stable while tr_ready_i=0.
- Latency:
  - An instruction with no writeback is visible on tr_valid_o the cycle after push.
  - Otherwise it is visible the cycle after its matching writeback, once it is at the head.
- Pointers wrap modulo DEPTH; count_o is updated as +push −pop.
- Flush (flush_i): next cycle all entries are invalid, pointers=0, count=0.
  - A push in the same cycle as flush is kept as the sole entry.
  - A pop in the same cycle completes normally; writebacks in that cycle are discarded.
- Deasserting rst_n mid-operation drops all entries immediately; there is no record output until the next push.

Decomposition:
- Add to cv32e40p_tracer_pkg:
  - trace_entry_t packed struct holding the fields above.
  - Constant TRACE_FP_REG_BIT = 5.
- Sub-module cv32e40p_trace_oldest_match: combinational head-relative priority find-first over DEPTH candidate bits, giving a one-hot match plus a found flag. It is instantiated twice, once for EX and once for LSU.

Test Plan:
- Reset, then push addi x5 (pc 0x80, rd_we=1), then ex_we x5=0x1234 -> next cycle tr_valid_o=1, tr_pc_o=0x80, tr_rd_o=5, tr_wdata_o=0x1234, count_o=1.
- Push lw x6 @0x100, then addi x7 @0x104, then ex_we x7=0x7 -> no tr_valid_o. Then lsu_we x6=0xDEAD -> records come out in order: 0x100/0xDEAD, then 0x104/0x7.
- Push two addi x5 (0x200, 0x204); ex_we x5=1, then ex_we x5=2 -> the first write completes 0x200 (wdata 1) and the second completes 0x204 (wdata 2).
- DEPTH=8, tr_ready_i=0, 9 pushes of a store (rd_we=0) -> count_o=8, overflow_o=1. The 9th PC never appears at the output. With tr_ready_i=1 and a push in the same cycle, the push is accepted and count stays 8.
- 3 entries pending, flush_i with a simultaneous push @0x300 (no rd) -> next cycle count_o=1, tr_pc_o=0x300. A later ex_we x5 sets spurious_o=1.
- tr_ready_i toggling 0/1 with 4 done entries -> each record is held stable while not ready, none is lost or duplicated, and count_o ends at 0.

Source files
------------

// File: rtl/cv32e40p_tracer_pkg.sv
// Shared types and constants for the instruction tracer and its retire buffer.
package cv32e40p_tracer_pkg;

  // Register address width; the top bit selects the FP register file.
  localparam int TRACE_ADDR_WIDTH = 6;
  localparam int TRACE_FP_REG_BIT = 5;

  // One in-flight instruction held until its writeback arrives.
  typedef struct packed {
    logic                        valid;
    logic                        done;
    logic                        is_load;
    logic                        rd_we;
    logic [TRACE_ADDR_WIDTH-1:0] rd;
    logic [31:0]                 pc;
    logic [31:0]                 instr;
    logic [31:0]                 wdata;
  } trace_entry_t;

endpackage

// File: rtl/cv32e40p_trace_oldest_match.sv
// Find-first over candidate bits, starting at the head slot and wrapping,
// so the selected bit is the oldest matching in-flight entry.
module cv32e40p_trace_oldest_match #(
  parameter int DEPTH = 8
) (
  input  logic [DEPTH-1:0]         cand_i,
  input  logic [$clog2(DEPTH)-1:0] head_i,
  output logic [DEPTH-1:0]         match_o,
  output logic                     found_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] idx;
  logic             found;

  // Walk slots in age order from the head; the first candidate wins.
  always_comb begin
    match_o = '0;
    found   = 1'b0;
    idx     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_i + PTR_W'(i);
      if (cand_i[idx] && !found) begin
        match_o[idx] = 1'b1;
        found        = 1'b1;
      end
    end
    found_o = found;
  end

endmodule

// File: rtl/cv32e40p_trace_retire_buffer.sv
// In-order retire buffer between ID issue and the tracer. Entries are recorded
// at issue, completed by EX or LSU writebacks, and released in program order.
module cv32e40p_trace_retire_buffer
  import cv32e40p_tracer_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = TRACE_ADDR_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush_i,
  input  logic                    id_valid_i,
  input  logic [31:0]             id_pc_i,
  input  logic [31:0]             id_instr_i,
  input  logic [ADDR_WIDTH-1:0]   id_rd_i,
  input  logic                    id_rd_we_i,
  input  logic                    id_is_load_i,
  input  logic                    ex_we_i,
  input  logic [ADDR_WIDTH-1:0]   ex_waddr_i,
  input  logic [31:0]             ex_wdata_i,
  input  logic                    lsu_we_i,
  input  logic [ADDR_WIDTH-1:0]   lsu_waddr_i,
  input  logic [31:0]             lsu_wdata_i,
  output logic                    tr_valid_o,
  input  logic                    tr_ready_i,
  output logic [31:0]             tr_pc_o,
  output logic [31:0]             tr_instr_o,
  output logic [ADDR_WIDTH-1:0]   tr_rd_o,
  output logic                    tr_rd_we_o,
  output logic [31:0]             tr_wdata_o,
  output logic [$clog2(DEPTH):0]  count_o,
  output logic                    overflow_o,
  output logic                    spurious_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  trace_entry_t     entries_q [DEPTH];
  trace_entry_t     entries_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             spurious_q, spurious_d;

  trace_entry_t     head_e, new_e;
  logic [DEPTH-1:0] ex_cand, lsu_cand, ex_hit, lsu_hit;
  logic             ex_found, lsu_found;
  logic             full, pop, push;

  assign head_e = entries_q[head_q];
  assign full   = (count_q == CNT_W'(DEPTH));
  assign pop    = tr_valid_o & tr_ready_i;
  // A flush frees every slot, so a push alongside it always fits.
  assign push   = id_valid_i & (flush_i | ~full | pop);

  assign tr_valid_o = head_e.valid & head_e.done;
  assign tr_pc_o    = head_e.pc;
  assign tr_instr_o = head_e.instr;
  assign tr_rd_o    = head_e.rd;
  assign tr_rd_we_o = head_e.rd_we;
  assign tr_wdata_o = head_e.wdata;
  assign count_o    = count_q;
  assign overflow_o = overflow_q;
  assign spurious_o = spurious_q;

  // Pending entries eligible for each writeback port (pre-edge contents only).
  always_comb begin
    ex_cand  = '0;
    lsu_cand = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ex_cand[i]  = entries_q[i].valid & ~entries_q[i].done & entries_q[i].rd_we &
                    ~entries_q[i].is_load & (entries_q[i].rd == ex_waddr_i);
      lsu_cand[i] = entries_q[i].valid & ~entries_q[i].done & entries_q[i].rd_we &
                    entries_q[i].is_load & (entries_q[i].rd == lsu_waddr_i);
    end
  end

  cv32e40p_trace_oldest_match #(.DEPTH(DEPTH)) u_ex_match (
    .cand_i  (ex_cand),
    .head_i  (head_q),
    .match_o (ex_hit),
    .found_o (ex_found)
  );

  cv32e40p_trace_oldest_match #(.DEPTH(DEPTH)) u_lsu_match (
    .cand_i  (lsu_cand),
    .head_i  (head_q),
    .match_o (lsu_hit),
    .found_o (lsu_found)
  );

  // Next buffer state: writebacks, then pop, then push (push may reuse the popped slot).
  always_comb begin
    entries_d  = entries_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    overflow_d = overflow_q | (id_valid_i & ~push);
    spurious_d = spurious_q | (~flush_i & ((ex_we_i & ~ex_found) | (lsu_we_i & ~lsu_found)));

    new_e         = '0;
    new_e.valid   = 1'b1;
    new_e.done    = ~id_rd_we_i;
    new_e.is_load = id_is_load_i;
    new_e.rd_we   = id_rd_we_i;
    new_e.rd      = id_rd_i;
    new_e.pc      = id_pc_i;
    new_e.instr   = id_instr_i;

    if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) entries_d[i].valid = 1'b0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      if (push) begin
        entries_d[0] = new_e;
        tail_d       = PTR_W'(1);
        count_d      = CNT_W'(1);
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ex_we_i && ex_hit[i]) begin
          entries_d[i].done  = 1'b1;
          entries_d[i].wdata = ex_wdata_i;
        end
        if (lsu_we_i && lsu_hit[i]) begin
          entries_d[i].done  = 1'b1;
          entries_d[i].wdata = lsu_wdata_i;
        end
      end
      if (pop) begin
        entries_d[head_q].valid = 1'b0;
        head_d = head_q + PTR_W'(1);
      end
      if (push) begin
        entries_d[tail_q] = new_e;
        tail_d = tail_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // State registers; reset clears every entry so the record outputs read zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      spurious_q <= 1'b0;
    end else begin
      entries_q  <= entries_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      spurious_q <= spurious_d;
    end
  end

endmodule

// File: tb/tb_cv32e40p_trace_retire_buffer.sv
// Scoreboard bench for the trace retire buffer: expected records are queued at
// issue and compared in order whenever the tracer handshake completes.
module tb_cv32e40p_trace_retire_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush_i;
  logic        id_valid_i;
  logic [31:0] id_pc_i;
  logic [31:0] id_instr_i;
  logic [5:0]  id_rd_i;
  logic        id_rd_we_i;
  logic        id_is_load_i;
  logic        ex_we_i;
  logic [5:0]  ex_waddr_i;
  logic [31:0] ex_wdata_i;
  logic        lsu_we_i;
  logic [5:0]  lsu_waddr_i;
  logic [31:0] lsu_wdata_i;
  logic        tr_valid_o;
  logic        tr_ready_i;
  logic [31:0] tr_pc_o;
  logic [31:0] tr_instr_o;
  logic [5:0]  tr_rd_o;
  logic        tr_rd_we_o;
  logic [31:0] tr_wdata_o;
  logic [3:0]  count_o;
  logic        overflow_o;
  logic        spurious_o;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [5:0]  rd;
    logic        rd_we;
    logic [31:0] wdata;
  } exp_t;

  exp_t exp_q[$];
  exp_t sb_e;
  int   checks = 0;
  int   errors = 0;

  cv32e40p_trace_retire_buffer #(.DEPTH(8), .ADDR_WIDTH(6)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (flush_i),
    .id_valid_i   (id_valid_i),
    .id_pc_i      (id_pc_i),
    .id_instr_i   (id_instr_i),
    .id_rd_i      (id_rd_i),
    .id_rd_we_i   (id_rd_we_i),
    .id_is_load_i (id_is_load_i),
    .ex_we_i      (ex_we_i),
    .ex_waddr_i   (ex_waddr_i),
    .ex_wdata_i   (ex_wdata_i),
    .lsu_we_i     (lsu_we_i),
    .lsu_waddr_i  (lsu_waddr_i),
    .lsu_wdata_i  (lsu_wdata_i),
    .tr_valid_o   (tr_valid_o),
    .tr_ready_i   (tr_ready_i),
    .tr_pc_o      (tr_pc_o),
    .tr_instr_o   (tr_instr_o),
    .tr_rd_o      (tr_rd_o),
    .tr_rd_we_o   (tr_rd_we_o),
    .tr_wdata_o   (tr_wdata_o),
    .count_o      (count_o),
    .overflow_o   (overflow_o),
    .spurious_o   (spurious_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog actual timeout required summary");
    $fatal(1, "watchdog");
  end

  // Compare every accepted record against the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && tr_valid_o && tr_ready_i) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected actual pc=%h required no record", tr_pc_o);
      end else begin
        sb_e = exp_q.pop_front();
        if (tr_pc_o !== sb_e.pc || tr_instr_o !== sb_e.instr || tr_rd_o !== sb_e.rd ||
            tr_rd_we_o !== sb_e.rd_we || tr_wdata_o !== sb_e.wdata) begin
          errors++;
          $display("FAIL sb_record actual pc=%h instr=%h rd=%0d we=%b wdata=%h required pc=%h instr=%h rd=%0d we=%b wdata=%h",
                   tr_pc_o, tr_instr_o, tr_rd_o, tr_rd_we_o, tr_wdata_o,
                   sb_e.pc, sb_e.instr, sb_e.rd, sb_e.rd_we, sb_e.wdata);
        end
      end
    end
  end

  function automatic logic [31:0] mk_instr(input logic [31:0] pc);
    return {pc[15:0], 16'h0013};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush_i = 0; id_valid_i = 0; id_pc_i = 0; id_instr_i = 0; id_rd_i = 0;
    id_rd_we_i = 0; id_is_load_i = 0; ex_we_i = 0; ex_waddr_i = 0; ex_wdata_i = 0;
    lsu_we_i = 0; lsu_waddr_i = 0; lsu_wdata_i = 0;
  endtask

  task automatic issue(input logic [31:0] pc, input logic [5:0] rd, input logic we,
                       input logic ld, input logic [31:0] wdata, input bit expect_out);
    exp_t e;
    id_valid_i = 1; id_pc_i = pc; id_instr_i = mk_instr(pc); id_rd_i = rd;
    id_rd_we_i = we; id_is_load_i = ld;
    if (expect_out) begin
      e.pc = pc; e.instr = mk_instr(pc); e.rd = rd; e.rd_we = we; e.wdata = we ? wdata : 32'h0;
      exp_q.push_back(e);
    end
    tick();
    id_valid_i = 0;
  endtask

  task automatic ex_wb(input logic [5:0] rd, input logic [31:0] data);
    ex_we_i = 1; ex_waddr_i = rd; ex_wdata_i = data;
    tick();
    ex_we_i = 0;
  endtask

  task automatic lsu_wb(input logic [5:0] rd, input logic [31:0] data);
    lsu_we_i = 1; lsu_waddr_i = rd; lsu_wdata_i = data;
    tick();
    lsu_we_i = 0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    tr_ready_i = 1;
    while (count_o != 0 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (count_o !== 4'd0) begin
      errors++;
      $display("FAIL %s_drain_count actual %0d required 0", name, count_o);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain_missing actual %0d records outstanding required 0", name, exp_q.size());
    end
    tr_ready_i = 0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    idle_inputs();
    tr_ready_i = 0;
    rst_n = 0;
    #3;
    checks++;
    if (tr_valid_o !== 1'b0 || count_o !== 4'd0 || overflow_o !== 1'b0 || spurious_o !== 1'b0 ||
        tr_pc_o !== 32'h0 || tr_wdata_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_state actual valid=%b count=%0d ovf=%b spur=%b pc=%h wdata=%h required all 0",
               tr_valid_o, count_o, overflow_o, spurious_o, tr_pc_o, tr_wdata_o);
    end
    tick();
    tick();
    rst_n = 1;
    tick();
  endtask

  task automatic test_basic();
    tr_ready_i = 0;
    issue(32'h80, 6'd5, 1'b1, 1'b0, 32'h1234, 1'b1);
    checks++;
    if (tr_valid_o !== 1'b0 || count_o !== 4'd1) begin
      errors++;
      $display("FAIL basic_pending actual valid=%b count=%0d required valid=0 count=1", tr_valid_o, count_o);
    end
    ex_wb(6'd5, 32'h1234);
    checks++;
    if (tr_valid_o !== 1'b1 || tr_pc_o !== 32'h80 || tr_rd_o !== 6'd5 || tr_wdata_o !== 32'h1234 ||
        tr_rd_we_o !== 1'b1 || count_o !== 4'd1) begin
      errors++;
      $display("FAIL basic_done actual valid=%b pc=%h rd=%0d wdata=%h count=%0d required 1 00000080 5 00001234 1",
               tr_valid_o, tr_pc_o, tr_rd_o, tr_wdata_o, count_o);
    end
    drain("basic");
  endtask

  task automatic test_in_order();
    tr_ready_i = 1;
    issue(32'h100, 6'd6, 1'b1, 1'b1, 32'hDEAD, 1'b1);
    issue(32'h104, 6'd7, 1'b1, 1'b0, 32'h7, 1'b1);
    ex_wb(6'd7, 32'h7);
    checks++;
    if (tr_valid_o !== 1'b0 || count_o !== 4'd2) begin
      errors++;
      $display("FAIL inorder_blocked actual valid=%b count=%0d required valid=0 count=2", tr_valid_o, count_o);
    end
    lsu_wb(6'd6, 32'hDEAD);
    drain("inorder");
  endtask

  task automatic test_same_rd();
    tr_ready_i = 0;
    issue(32'h200, 6'd5, 1'b1, 1'b0, 32'h1, 1'b1);
    issue(32'h204, 6'd5, 1'b1, 1'b0, 32'h2, 1'b1);
    ex_wb(6'd5, 32'h1);
    ex_wb(6'd5, 32'h2);
    checks++;
    if (count_o !== 4'd2 || tr_valid_o !== 1'b1 || tr_pc_o !== 32'h200 || tr_wdata_o !== 32'h1) begin
      errors++;
      $display("FAIL samerd_head actual count=%0d valid=%b pc=%h wdata=%h required 2 1 00000200 00000001",
               count_o, tr_valid_o, tr_pc_o, tr_wdata_o);
    end
    drain("samerd");
  endtask

  task automatic test_overflow();
    exp_t e;
    tr_ready_i = 0;
    for (int i = 0; i < 9; i++) issue(32'h400 + 32'(4 * i), 6'd0, 1'b0, 1'b0, 32'h0, i < 8);
    checks++;
    if (count_o !== 4'd8 || overflow_o !== 1'b1 || tr_pc_o !== 32'h400) begin
      errors++;
      $display("FAIL overflow_full actual count=%0d ovf=%b pc=%h required 8 1 00000400", count_o, overflow_o, tr_pc_o);
    end
    id_valid_i = 1; id_pc_i = 32'h500; id_instr_i = mk_instr(32'h500); id_rd_i = 0;
    id_rd_we_i = 0; id_is_load_i = 0;
    e.pc = 32'h500; e.instr = mk_instr(32'h500); e.rd = 0; e.rd_we = 0; e.wdata = 0;
    exp_q.push_back(e);
    tr_ready_i = 1;
    tick();
    id_valid_i = 0;
    tr_ready_i = 0;
    checks++;
    if (count_o !== 4'd8 || tr_pc_o !== 32'h404) begin
      errors++;
      $display("FAIL overflow_pushpop actual count=%0d pc=%h required 8 00000404", count_o, tr_pc_o);
    end
    drain("overflow");
  endtask

  task automatic test_flush();
    exp_t e;
    tr_ready_i = 0;
    for (int i = 0; i < 3; i++) issue(32'h280 + 32'(4 * i), 6'd5, 1'b1, 1'b0, 32'h0, 1'b0);
    checks++;
    if (count_o !== 4'd3 || spurious_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_pre actual count=%0d spur=%b required 3 0", count_o, spurious_o);
    end
    flush_i = 1;
    id_valid_i = 1; id_pc_i = 32'h300; id_instr_i = mk_instr(32'h300); id_rd_i = 0;
    id_rd_we_i = 0; id_is_load_i = 0;
    e.pc = 32'h300; e.instr = mk_instr(32'h300); e.rd = 0; e.rd_we = 0; e.wdata = 0;
    exp_q.push_back(e);
    tick();
    flush_i = 0;
    id_valid_i = 0;
    checks++;
    if (count_o !== 4'd1 || tr_valid_o !== 1'b1 || tr_pc_o !== 32'h300 || overflow_o !== 1'b1) begin
      errors++;
      $display("FAIL flush_post actual count=%0d valid=%b pc=%h ovf=%b required 1 1 00000300 1",
               count_o, tr_valid_o, tr_pc_o, overflow_o);
    end
    ex_wb(6'd5, 32'h55);
    checks++;
    if (spurious_o !== 1'b1) begin
      errors++;
      $display("FAIL flush_spurious actual %b required 1", spurious_o);
    end
    drain("flush");
  endtask

  task automatic test_back_pressure();
    logic        prev_v, prev_r;
    logic [31:0] prev_pc;
    int          n = 0;
    tr_ready_i = 0;
    issue(32'h600, 6'd0, 1'b0, 1'b0, 32'h0, 1'b1);
    checks++;
    if (tr_valid_o !== 1'b1 || tr_pc_o !== 32'h600) begin
      errors++;
      $display("FAIL bp_latency actual valid=%b pc=%h required 1 00000600", tr_valid_o, tr_pc_o);
    end
    for (int i = 1; i < 4; i++) issue(32'h600 + 32'(4 * i), 6'd0, 1'b0, 1'b0, 32'h0, 1'b1);
    while (count_o != 0 && n < 60) begin
      prev_v = tr_valid_o;
      prev_pc = tr_pc_o;
      tr_ready_i = (n % 3) != 0;
      prev_r = tr_ready_i;
      tick();
      if (prev_v && !prev_r) begin
        checks++;
        if (tr_valid_o !== 1'b1 || tr_pc_o !== prev_pc) begin
          errors++;
          $display("FAIL bp_hold actual valid=%b pc=%h required 1 %h", tr_valid_o, tr_pc_o, prev_pc);
        end
      end
      n++;
    end
    drain("bp");
  endtask

  task automatic test_mid_reset();
    tr_ready_i = 0;
    issue(32'h700, 6'd0, 1'b0, 1'b0, 32'h0, 1'b0);
    rst_n = 0;
    #2;
    checks++;
    if (tr_valid_o !== 1'b0 || count_o !== 4'd0 || overflow_o !== 1'b0 || spurious_o !== 1'b0) begin
      errors++;
      $display("FAIL midreset actual valid=%b count=%0d ovf=%b spur=%b required all 0",
               tr_valid_o, count_o, overflow_o, spurious_o);
    end
    tick();
    rst_n = 1;
    tick();
    tick();
    checks++;
    if (tr_valid_o !== 1'b0 || count_o !== 4'd0) begin
      errors++;
      $display("FAIL midreset_after actual valid=%b count=%0d required 0 0", tr_valid_o, count_o);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_in_order();
    test_same_rd();
    test_overflow();
    test_flush();
    test_back_pressure();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
